// File: rtl/led_pattern_seq.sv
// LED pattern sequencer: STOP/ROTATE/BOUNCE/BLINK patterns paced by a prescaler, driven by a command port.
// Latency: command accepted at edge N shows its seed from cycle N+2; first step lands in cycle N+3+period.
// Backpressure: cmd_ready drops for the single LOAD cycle after an accept; otherwise commands are always taken.
module led_pattern_seq #(
    parameter int CNT_W = 15,
    parameter int LED_W = 10
) (
    input  logic             OSC_50m,
    input  logic             io_master_reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_mode,
    input  logic [CNT_W-1:0] cmd_period,
    input  logic [LED_W-1:0] cmd_seed,
    output logic [LED_W-1:0] USER_LED,
    output logic             step_pulse,
    output logic             busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    localparam logic [1:0] MODE_STOP   = 2'd0;
    localparam logic [1:0] MODE_ROTATE = 2'd1;
    localparam logic [1:0] MODE_BOUNCE = 2'd2;
    localparam logic [1:0] MODE_BLINK  = 2'd3;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    logic [1:0]       state_q, state_d;
    logic [LED_W-1:0] led_q, led_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [1:0]       mode_q, mode_d;
    logic [LED_W-1:0] seed_q, seed_d;
    logic             dir_q, dir_d;
    logic             step_pulse_q, step_pulse_d;

    logic             cmd_accept;
    logic [LED_W-1:0] step_led;
    logic             step_dir;

    assign cmd_ready  = (state_q != ST_LOAD);
    assign busy       = (state_q != ST_IDLE);
    assign cmd_accept = cmd_valid & cmd_ready;
    assign USER_LED   = led_q;
    assign step_pulse = step_pulse_q;

    // Next pattern and bounce direction if a step were to fire this cycle
    always_comb begin
        step_led = led_q;
        step_dir = dir_q;
        case (mode_q)
            MODE_ROTATE: step_led = {led_q[LED_W-2:0], led_q[LED_W-1]};
            MODE_BOUNCE: begin
                // Reverse on reaching an end so the end LED is not shown twice
                if (dir_q == DIR_LEFT) begin
                    if (led_q[LED_W-1]) begin
                        step_dir = DIR_RIGHT;
                        step_led = led_q >> 1;
                    end else begin
                        step_led = led_q << 1;
                    end
                end else begin
                    if (led_q[0]) begin
                        step_dir = DIR_LEFT;
                        step_led = led_q << 1;
                    end else begin
                        step_led = led_q >> 1;
                    end
                end
            end
            MODE_BLINK:  step_led = led_q ^ seed_q;
            default:     step_led = led_q;
        endcase
    end

    // FSM, prescaler and command capture; command fields are captured on the accept edge
    // so LOAD works from registered values even if the requester changes its inputs.
    always_comb begin
        state_d      = state_q;
        led_d        = led_q;
        cnt_d        = cnt_q;
        period_d     = period_q;
        mode_d       = mode_q;
        seed_d       = seed_q;
        dir_d        = dir_q;
        step_pulse_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (cmd_accept) begin
                    state_d  = ST_LOAD;
                    mode_d   = cmd_mode;
                    period_d = cmd_period;
                    seed_d   = cmd_seed;
                end
            end
            ST_LOAD: begin
                cnt_d = '0;
                dir_d = DIR_LEFT;
                if (mode_q == MODE_STOP) begin
                    led_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    led_d   = seed_q;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (cmd_accept) begin
                    // A new command overrides any step due this cycle
                    state_d  = ST_LOAD;
                    mode_d   = cmd_mode;
                    period_d = cmd_period;
                    seed_d   = cmd_seed;
                    cnt_d    = '0;
                end else if (cnt_q == period_q) begin
                    cnt_d        = '0;
                    led_d        = step_led;
                    dir_d        = step_dir;
                    step_pulse_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge OSC_50m) begin
        if (io_master_reset) begin
            state_q      <= ST_IDLE;
            led_q        <= LED_W'(1);
            cnt_q        <= '0;
            period_q     <= '1;
            mode_q       <= MODE_STOP;
            seed_q       <= '0;
            dir_q        <= DIR_LEFT;
            step_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            led_q        <= led_d;
            cnt_q        <= cnt_d;
            period_q     <= period_d;
            mode_q       <= mode_d;
            seed_q       <= seed_d;
            dir_q        <= dir_d;
            step_pulse_q <= step_pulse_d;
        end
    end

endmodule

// File: tb/tb_led_pattern_seq.sv
// Bench for led_pattern_seq: directed scenarios plus random commands and resets.
// Expected outputs per cycle are pushed by the driver's reference model and popped by a monitor.
// The monitor compares on the falling edge, away from the active clock edge.
module tb_led_pattern_seq;

    localparam int CNT_W = 15;
    localparam int LED_W = 10;

    logic             OSC_50m;
    logic             io_master_reset;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_mode;
    logic [CNT_W-1:0] cmd_period;
    logic [LED_W-1:0] cmd_seed;
    logic [LED_W-1:0] USER_LED;
    logic             step_pulse;
    logic             busy;

    led_pattern_seq #(.CNT_W(CNT_W), .LED_W(LED_W)) dut (
        .OSC_50m         (OSC_50m),
        .io_master_reset (io_master_reset),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_mode        (cmd_mode),
        .cmd_period      (cmd_period),
        .cmd_seed        (cmd_seed),
        .USER_LED        (USER_LED),
        .step_pulse      (step_pulse),
        .busy            (busy)
    );

    typedef struct packed {
        logic [9:0] led;
        logic       pulse;
        logic       busy;
        logic       ready;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model state: time since the last accepted command and its parameters
    bit         m_has   = 0;
    int         m_t     = 0;
    logic [1:0] m_mode  = 2'd0;
    int         m_per   = 0;
    logic [9:0] m_seed  = '0;
    int         m_k     = 0;
    logic [9:0] m_bled  = '0;
    bit         m_bdir  = 0;
    logic [9:0] m_led   = 10'h001;
    bit         m_ready = 1;

    initial begin
        OSC_50m = 1'b0;
        forever #5 OSC_50m = ~OSC_50m;
    end

    function automatic logic [9:0] rotl(input logic [9:0] s, input int r);
        logic [9:0] v;
        if (r == 0) return s;
        v = (s << r) | (s >> (LED_W - r));
        return v;
    endfunction

    // Advance the bounce pattern one step following the end-reversal rule
    task automatic bounce_advance();
        if (!m_bdir) begin
            if (m_bled[9]) begin m_bdir = 1; m_bled = m_bled >> 1; end
            else m_bled = m_bled << 1;
        end else begin
            if (m_bled[0]) begin m_bdir = 0; m_bled = m_bled << 1; end
            else m_bled = m_bled >> 1;
        end
    endtask

    // Predict the outputs visible after this clock edge
    task automatic model_edge(input bit rst, input bit vld, input logic [1:0] md,
                              input int per, input logic [9:0] sd);
        exp_t e;
        int   p;
        int   k;
        bit   pls;
        if (rst) begin
            m_has   = 0;
            m_led   = 10'h001;
            m_ready = 1;
            e = '{led: m_led, pulse: 1'b0, busy: 1'b0, ready: 1'b1};
        end else if (vld && m_ready) begin
            m_has   = 1;
            m_t     = 1;
            m_mode  = md;
            m_per   = per;
            m_seed  = sd;
            m_k     = 0;
            m_bled  = sd;
            m_bdir  = 0;
            m_ready = 0;
            e = '{led: m_led, pulse: 1'b0, busy: 1'b1, ready: 1'b0};
        end else if (m_has) begin
            m_t++;
            m_ready = 1;
            if (m_mode == 2'd0) begin
                m_has = 0;
                m_led = '0;
                e = '{led: m_led, pulse: 1'b0, busy: 1'b0, ready: 1'b1};
            end else begin
                p   = m_per + 1;
                k   = (m_t - 2) / p;
                pls = (m_t >= 3) && (((m_t - 2) % p) == 0);
                case (m_mode)
                    2'd1: m_led = rotl(m_seed, k % LED_W);
                    2'd2: begin
                        while (m_k < k) begin
                            bounce_advance();
                            m_k++;
                        end
                        m_led = m_bled;
                    end
                    default: m_led = (k % 2 == 1) ? 10'h000 : m_seed;
                endcase
                e = '{led: m_led, pulse: pls, busy: 1'b1, ready: 1'b1};
            end
        end else begin
            m_ready = 1;
            e = '{led: m_led, pulse: 1'b0, busy: 1'b0, ready: 1'b1};
        end
        exp_q.push_back(e);
    endtask

    // One clock cycle of stimulus; the model sees exactly what the DUT samples
    task automatic cyc(input bit rst, input bit vld, input logic [1:0] md,
                       input int per, input logic [9:0] sd);
        io_master_reset = rst;
        cmd_valid       = vld;
        cmd_mode        = md;
        cmd_period      = CNT_W'(per);
        cmd_seed        = sd;
        @(posedge OSC_50m);
        model_edge(rst, vld, md, per, sd);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 2'd0, 0, 10'h000);
    endtask

    // Monitor: pop one expectation per cycle and compare against the DUT
    initial begin
        exp_t e;
        forever begin
            @(negedge OSC_50m);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_tests++;
                if ({USER_LED, step_pulse, busy, cmd_ready} !== e) begin
                    n_fail++;
                    $display("FAIL outputs @%0t: got led=%h pulse=%b busy=%b rdy=%b, want led=%h pulse=%b busy=%b rdy=%b",
                             $time, USER_LED, step_pulse, busy, cmd_ready,
                             e.led, e.pulse, e.busy, e.ready);
                end
            end
        end
    end

    initial begin
        int         r;
        bit         rst;
        bit         vld;
        logic [1:0] md;
        int         per;
        logic [9:0] sd;
        int         waited;

        io_master_reset = 1'b1;
        cmd_valid       = 1'b0;
        cmd_mode        = 2'd0;
        cmd_period      = '0;
        cmd_seed        = '0;

        // Reset held two cycles, then idle
        cyc(1, 0, 2'd0, 0, 10'h000);
        cyc(1, 0, 2'd0, 0, 10'h000);
        idle(2);

        // ROTATE, seed 0x001, period 2: full lap plus wrap
        cyc(0, 1, 2'd1, 2, 10'h001);
        idle(36);

        // BOUNCE, seed 0x001, period 0: out to the top end and back past the bottom
        cyc(0, 1, 2'd2, 0, 10'h001);
        idle(24);

        // BLINK, seed 0x155, period 4
        cyc(0, 1, 2'd3, 4, 10'h155);
        idle(20);

        // New command lands on a step cycle, followed by a valid held through LOAD
        cyc(0, 1, 2'd1, 2, 10'h001);
        idle(3);
        cyc(0, 1, 2'd3, 1, 10'h3FF);
        cyc(0, 1, 2'd1, 1, 10'h003);
        cyc(0, 1, 2'd1, 1, 10'h003);
        idle(10);

        // STOP during RUN
        cyc(0, 1, 2'd1, 1, 10'h005);
        idle(6);
        cyc(0, 1, 2'd0, 3, 10'h2AA);
        idle(4);

        // Reset mid-RUN
        cyc(0, 1, 2'd2, 1, 10'h010);
        idle(5);
        cyc(1, 0, 2'd0, 0, 10'h000);
        idle(3);

        // Reset mid-LOAD drops the pending command
        cyc(0, 1, 2'd1, 0, 10'h0F0);
        cyc(1, 0, 2'd0, 0, 10'h000);
        idle(3);

        // Seed 0 keeps the LEDs dark but still pulses
        cyc(0, 1, 2'd1, 1, 10'h000);
        idle(8);
        cyc(0, 1, 2'd2, 0, 10'h000);
        idle(4);

        // Random commands, periods, seeds and occasional resets
        for (int i = 0; i < 4000; i++) begin
            r   = int'($urandom_range(0, 299));
            rst = (r == 0);
            vld = ($urandom_range(0, 14) == 0);
            md  = 2'($urandom_range(0, 3));
            per = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 40))
                                              : int'($urandom_range(0, 4));
            if ($urandom_range(0, 1) == 0) sd = 10'(1) << $urandom_range(0, 9);
            else                           sd = 10'($urandom_range(0, 1023));
            cyc(rst, vld, md, per, sd);
        end
        idle(2);

        // Let the monitor drain, bounded
        waited = 0;
        while (exp_q.size() > 0 && waited < 20) begin
            @(posedge OSC_50m);
            waited++;
        end
        #6;
        if (exp_q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
